// File: rtl/lvt_mem_initiator_if.sv
// Command, response and memory-port bundle for the LVT memory initiator.
// The master modport is the initiator's view; the slave modport is the requester/memory side.
interface lvt_mem_initiator_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic                  mem_wr0_en;
  logic [ADDR_WIDTH-1:0] mem_wr0_addr;
  logic [DATA_WIDTH-1:0] mem_wr0_data;
  logic                  mem_wr1_en;
  logic [ADDR_WIDTH-1:0] mem_wr1_addr;
  logic [DATA_WIDTH-1:0] mem_wr1_data;
  logic                  mem_rd0_en;
  logic [ADDR_WIDTH-1:0] mem_rd0_addr;
  logic [DATA_WIDTH-1:0] mem_rd0_data;

  logic                  busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, mem_rd0_data,
    output cmd_ready, rsp_valid, rsp_data,
    output mem_wr0_en, mem_wr0_addr, mem_wr0_data,
    output mem_wr1_en, mem_wr1_addr, mem_wr1_data,
    output mem_rd0_en, mem_rd0_addr, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, mem_rd0_data,
    input  cmd_ready, rsp_valid, rsp_data,
    input  mem_wr0_en, mem_wr0_addr, mem_wr0_data,
    input  mem_wr1_en, mem_wr1_addr, mem_wr1_data,
    input  mem_rd0_en, mem_rd0_addr, busy
  );
endinterface

// File: rtl/lvt_mem_initiator.sv
// Queues read/write commands and issues them to a 2-write/1-read LVT memory,
// pairing consecutive writes onto wr0/wr1 and returning read data in order.
module lvt_mem_initiator #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  lvt_mem_initiator_if.master  bus
);
  localparam int IW = $clog2(CMD_DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(CMD_DEPTH);

  logic                  cmd_write_mem [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] cmd_addr_mem  [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] cmd_wdata_mem [CMD_DEPTH];

  logic [PW-1:0] cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d, cmd_cnt;
  logic [IW-1:0] head_idx, next_idx;
  logic          push, h_valid, n_valid, h_write, n_write;
  logic [1:0]    pop_cnt;

  logic                  wr0_en_q, wr0_en_d, wr1_en_q, wr1_en_d, rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] wr0_addr_q, wr0_addr_d, wr1_addr_q, wr1_addr_d, rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] wr0_data_q, wr0_data_d, wr1_data_q, wr1_data_d;
  logic                  cap_q, cap_d;

  logic [1:0]            rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d, rsp_cnt;
  logic [DATA_WIDTH-1:0] rsp_mem_q [2];
  logic                  rsp_pop;
  logic [2:0]            pending;
  logic                  slot_free;

  assign cmd_cnt       = cmd_wp_q - cmd_rp_q;
  assign bus.cmd_ready = !rst && (cmd_cnt != FULL_CNT);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign head_idx      = cmd_rp_q[IW-1:0];
  assign next_idx      = head_idx + IW'(1);
  assign h_valid       = (cmd_cnt != '0);
  assign n_valid       = (cmd_cnt > PW'(1));
  assign h_write       = cmd_write_mem[head_idx];
  assign n_write       = cmd_write_mem[next_idx];

  // Slots are counted from registered state only, so a same-cycle pop frees nothing yet.
  assign rsp_cnt   = rsp_wp_q - rsp_rp_q;
  assign pending   = {1'b0, rsp_cnt} + {2'b00, rd_en_q} + {2'b00, cap_q};
  assign slot_free = (pending < 3'd2);
  assign rsp_pop   = bus.rsp_valid && bus.rsp_ready;

  always_comb begin
    wr0_en_d   = 1'b0;
    wr1_en_d   = 1'b0;
    rd_en_d    = 1'b0;
    wr0_addr_d = wr0_addr_q;
    wr0_data_d = wr0_data_q;
    wr1_addr_d = wr1_addr_q;
    wr1_data_d = wr1_data_q;
    rd_addr_d  = rd_addr_q;
    pop_cnt    = 2'd0;
    if (h_valid && h_write) begin
      wr0_en_d   = 1'b1;
      wr0_addr_d = cmd_addr_mem[head_idx];
      wr0_data_d = cmd_wdata_mem[head_idx];
      pop_cnt    = 2'd1;
      // The younger write goes on wr1 so the memory's wr1 priority keeps program order.
      if (n_valid && n_write) begin
        wr1_en_d   = 1'b1;
        wr1_addr_d = cmd_addr_mem[next_idx];
        wr1_data_d = cmd_wdata_mem[next_idx];
        pop_cnt    = 2'd2;
      end
    end else if (h_valid && slot_free) begin
      rd_en_d   = 1'b1;
      rd_addr_d = cmd_addr_mem[head_idx];
      pop_cnt   = 2'd1;
    end
    cmd_wp_d = cmd_wp_q + {{(PW-1){1'b0}}, push};
    cmd_rp_d = cmd_rp_q + PW'(pop_cnt);
    cap_d    = rd_en_q;
    rsp_wp_d = rsp_wp_q + {1'b0, cap_q};
    rsp_rp_d = rsp_rp_q + {1'b0, rsp_pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      cmd_write_mem[cmd_wp_q[IW-1:0]] <= bus.cmd_write;
      cmd_addr_mem[cmd_wp_q[IW-1:0]]  <= bus.cmd_addr;
      cmd_wdata_mem[cmd_wp_q[IW-1:0]] <= bus.cmd_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wp_q     <= '0;
      cmd_rp_q     <= '0;
      wr0_en_q     <= 1'b0;
      wr1_en_q     <= 1'b0;
      rd_en_q      <= 1'b0;
      wr0_addr_q   <= '0;
      wr0_data_q   <= '0;
      wr1_addr_q   <= '0;
      wr1_data_q   <= '0;
      rd_addr_q    <= '0;
      cap_q        <= 1'b0;
      rsp_wp_q     <= '0;
      rsp_rp_q     <= '0;
      rsp_mem_q[0] <= '0;
      rsp_mem_q[1] <= '0;
    end else begin
      cmd_wp_q   <= cmd_wp_d;
      cmd_rp_q   <= cmd_rp_d;
      wr0_en_q   <= wr0_en_d;
      wr1_en_q   <= wr1_en_d;
      rd_en_q    <= rd_en_d;
      wr0_addr_q <= wr0_addr_d;
      wr0_data_q <= wr0_data_d;
      wr1_addr_q <= wr1_addr_d;
      wr1_data_q <= wr1_data_d;
      rd_addr_q  <= rd_addr_d;
      cap_q      <= cap_d;
      rsp_wp_q   <= rsp_wp_d;
      rsp_rp_q   <= rsp_rp_d;
      if (cap_q) rsp_mem_q[rsp_wp_q[0]] <= bus.mem_rd0_data;
    end
  end

  assign bus.mem_wr0_en   = wr0_en_q;
  assign bus.mem_wr0_addr = wr0_addr_q;
  assign bus.mem_wr0_data = wr0_data_q;
  assign bus.mem_wr1_en   = wr1_en_q;
  assign bus.mem_wr1_addr = wr1_addr_q;
  assign bus.mem_wr1_data = wr1_data_q;
  assign bus.mem_rd0_en   = rd_en_q;
  assign bus.mem_rd0_addr = rd_addr_q;
  assign bus.rsp_valid    = (rsp_cnt != 2'd0);
  assign bus.rsp_data     = rsp_mem_q[rsp_rp_q[0]];
  assign bus.busy         = (cmd_cnt != '0) || rd_en_q || cap_q || (rsp_cnt != 2'd0);
endmodule

// File: tb/tb_lvt_mem_initiator.sv
// Scoreboard bench: commands update a program-order reference memory at acceptance,
// a negedge monitor pops expected read data and checks port-level rules.
module tb_lvt_mem_initiator;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lvt_mem_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  lvt_mem_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [DW-1:0] env_mem [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] rd_data_r;
  logic [DW-1:0] exp_q [$];
  int rd_issues = 0;
  int wr_issues = 0;
  int dual_count = 0;
  int rsp_count = 0;
  int accepted = 0;
  logic [AW-1:0] dual_a0, dual_a1;
  logic [DW-1:0] dual_d0, dual_d1;
  logic prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic rand_done;

  assign bus.mem_rd0_data = rd_data_r;

  // Environment memory: registered read, wr1 wins a same-address collision.
  always @(posedge clk) begin
    if (bus.mem_wr0_en) env_mem[bus.mem_wr0_addr] <= bus.mem_wr0_data;
    if (bus.mem_wr1_en) env_mem[bus.mem_wr1_addr] <= bus.mem_wr1_data;
    if (bus.mem_rd0_en) rd_data_r <= env_mem[bus.mem_rd0_addr];
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd0_en) begin
        rd_issues++;
        check("rd_wr_exclusive", 32'({bus.mem_wr0_en, bus.mem_wr1_en}), 32'd0);
      end
      if (bus.mem_wr0_en) wr_issues++;
      if (bus.mem_wr1_en) wr_issues++;
      if (bus.mem_wr0_en && bus.mem_wr1_en) begin
        dual_count++;
        dual_a0 = bus.mem_wr0_addr; dual_a1 = bus.mem_wr1_addr;
        dual_d0 = bus.mem_wr0_data; dual_d1 = bus.mem_wr1_data;
      end
      if (prev_hold) begin
        check("rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
        check("rsp_data_stable", bus.rsp_data, prev_data);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL rsp_unexpected: got %h, expected no response", bus.rsp_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          rsp_count++;
          check("rsp_data", bus.rsp_data, e);
          $display("rsp %0d: data %h expected %h", rsp_count, bus.rsp_data, e);
        end
      end
      prev_hold = bus.rsp_valid && !bus.rsp_ready;
      prev_data = bus.rsp_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
    @(negedge clk);
    while (!bus.cmd_ready && t < 300) begin t++; @(negedge clk); end
    if (!bus.cmd_ready) begin
      n_vec++; n_bad++;
      $display("FAIL push_timeout: cmd_ready stayed 0, expected 1 (addr %h)", a);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    accepted++;
    if (w) ref_mem[a] = d;
    else   exp_q.push_back(ref_mem[a]);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((bus.busy || exp_q.size() != 0) && t < 3000) begin t++; @(negedge clk); end
    if (bus.busy || exp_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: busy %0d pending %0d, expected 0 0", bus.busy, exp_q.size());
    end
    cycles(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_enables"}, 32'({bus.mem_wr0_en, bus.mem_wr1_en, bus.mem_rd0_en}), 32'd0);
    check({tag, "_addrs"}, 32'({bus.mem_wr0_addr, bus.mem_wr1_addr, bus.mem_rd0_addr}), 32'd0);
    check({tag, "_wr0_data"}, bus.mem_wr0_data, 32'd0);
    check({tag, "_wr1_data"}, bus.mem_wr1_data, 32'd0);
    check({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
  endtask

  initial begin
    int base, dbase, acc0, iss0, t;
    for (int i = 0; i < 2**AW; i++) begin env_mem[i] = '0; ref_mem[i] = '0; end
    rd_data_r = '0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;

    cycles(3);
    check_reset_outputs("por");
    @(negedge clk); rst = 1'b0;
    cycles(1);
    check("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    // Write then read of the same address.
    bus.rsp_ready = 1'b1;
    push(1'b1, 7'h10, 32'hA5A5A5A5);
    push(1'b0, 7'h10, 32'h0);
    wait_idle();

    for (int i = 0; i < 4; i++) push(1'b1, AW'(7'h20 + i), 32'hC0DE0000 + i);
    wait_idle();

    // Four reads with the consumer stalled: only two may issue.
    bus.rsp_ready = 1'b0;
    base = rd_issues;
    for (int i = 0; i < 4; i++) push(1'b0, AW'(7'h20 + i), 32'h0);
    cycles(8);
    check("rd_issued_stalled", rd_issues - base, 32'd2);
    check("rsp_valid_stalled", 32'(bus.rsp_valid), 32'd1);
    check("rsp_head_stalled", bus.rsp_data, exp_q[0]);

    // Two writes queue behind the blocked reads and fill the command FIFO.
    dbase = dual_count;
    push(1'b1, 7'h05, 32'h11111111);
    push(1'b1, 7'h05, 32'h22222222);
    cycles(2);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 7'h05;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_not_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    check("no_dual_while_blocked", dual_count - dbase, 32'd0);

    cycles(1); pop_one(); base = rd_issues; cycles(4);
    check("rd_resume_pop1", rd_issues - base, 32'd1);
    pop_one(); base = rd_issues; cycles(4);
    check("rd_resume_pop2", rd_issues - base, 32'd1);
    check("dual_write_count", dual_count - dbase, 32'd1);
    check("dual_wr0_addr", 32'(dual_a0), 32'h05);
    check("dual_wr1_addr", 32'(dual_a1), 32'h05);
    check("dual_wr0_data", dual_d0, 32'h11111111);
    check("dual_wr1_data", dual_d1, 32'h22222222);
    bus.rsp_ready = 1'b1;
    push(1'b0, 7'h05, 32'h0);
    wait_idle();

    // Reset with one read in flight and three commands queued.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(1'b0, AW'(7'h20 + (i % 4)), 32'h0);
    cycles(4);
    pop_one();
    t = 0;
    while (!bus.mem_rd0_en && t < 20) begin t++; @(negedge clk); end
    check("inflight_before_reset", 32'(bus.mem_rd0_en), 32'd1);
    check("busy_before_reset", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    cycles(2);
    @(negedge clk); rst = 1'b0;
    bus.rsp_ready = 1'b1;
    cycles(1);
    check("ready_after_midrst", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_rsp_after_reset", 32'(bus.rsp_valid), 32'd0);
    end
    cycles(1);

    // Randomized mix against the program-order reference memory.
    acc0 = accepted;
    iss0 = rd_issues + wr_issues;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic w;
          logic [AW-1:0] a;
          logic [DW-1:0] d;
          int gap;
          w = 1'($urandom_range(0, 1));
          a = AW'($urandom_range(0, 15));
          d = $urandom;
          gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
          if (gap != 0) begin repeat (gap) @(posedge clk); #1; end
          push(w, a, d);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.rsp_ready = 1'b1;
    wait_idle();
    check("issue_count", (rd_issues + wr_issues) - iss0, accepted - acc0);
    check("final_busy", 32'(bus.busy), 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/lvt_mem_initiator.md
LVT_MEM_INITIATOR -- requirements
Module: lvt_mem_initiator

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, sets the memory address width.
REQ-002 Parameter DATA_WIDTH, default 32, sets the memory data width.
REQ-003 Parameter CMD_DEPTH, default 4, sets command FIFO entries; it SHALL be a power of two and at least 2.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port cmd_valid/cmd_ready, input/output, 1 bit each: command handshake; a transfer occurs when both are high at a clk edge.
REQ-007 Port cmd_write, input, 1 bit: 1 means write, 0 means read.
REQ-008 Ports cmd_addr (ADDR_WIDTH) and cmd_wdata (DATA_WIDTH), inputs: command address and write data; cmd_wdata is ignored for reads.
REQ-009 Port rsp_valid/rsp_ready, output/input, 1 bit each: read-response handshake.
REQ-010 Port rsp_data, output, DATA_WIDTH: read data, in command order.
REQ-011 Ports mem_wr0_en, mem_wr0_addr, mem_wr0_data, output, 1/ADDR_WIDTH/DATA_WIDTH: memory write port 0.
REQ-012 Ports mem_wr1_en, mem_wr1_addr, mem_wr1_data, output, 1/ADDR_WIDTH/DATA_WIDTH: memory write port 1.
REQ-013 Ports mem_rd0_en (output, 1 bit), mem_rd0_addr (output, ADDR_WIDTH) and mem_rd0_data (input, DATA_WIDTH): memory read port; read data is valid one cycle after mem_rd0_en.
REQ-014 Port busy, output, 1 bit: high while any command is queued, any read is in flight, or any response is held.

Function
REQ-015 Commands SHALL enter a CMD_DEPTH FIFO.
- cmd_ready = FIFO not full.
- A simultaneous push and pop when the FIFO is full is not accepted; cmd_ready governs.
REQ-016 Each cycle the dispatcher SHALL examine the FIFO head (H) and the next entry (N) and take the first matching action:
- (a) H and N are both writes: issue H on wr0 and N on wr1, then pop 2.
- (b) H is a write: issue H on wr0 and pop 1.
- (c) H is a read and a response slot is free: issue the read on rd0 and pop 1.
- (d) Otherwise: issue nothing.
REQ-017 In rule (a), the later write SHALL always use wr1, so that write-port-1 priority in the memory preserves program order when both writes target the same address.
REQ-018 mem_rd0_en SHALL never be asserted in a cycle where mem_wr0_en or mem_wr1_en is high, and a read SHALL never share an issue cycle with a write.
REQ-019 A read issued in cycle T SHALL capture mem_rd0_data at the edge ending cycle T+1 into a 2-entry response FIFO; rsp_valid SHALL rise no earlier than cycle T+2.
REQ-020 The response-slot check in rule (c) SHALL satisfy: response FIFO occupancy + in-flight reads < 2.
- A response popped in the same cycle SHALL NOT free a slot until the next cycle.
REQ-021 The memory port outputs SHALL be registered.
- Enables are high for exactly one cycle per issued operation.
- Address and data outputs hold their last value when the enable is low.
REQ-022 A write issued in cycle T followed by a read of the same address issued in cycle T+1 or later SHALL return the new data; no extra stall is inserted.
REQ-023 rsp_data SHALL be stable while rsp_valid is high and rsp_ready is low.
- rsp_valid is high whenever the response FIFO is non-empty.
REQ-024 The FIFO read and write pointers SHALL wrap modulo depth.
- Full and empty are distinguished by an extra pointer bit or an occupancy counter.
REQ-025 busy SHALL be the OR of: command FIFO non-empty, read in flight, and response FIFO non-empty.

Reset
REQ-026 While rst is high, the following SHALL be low independent of clk: cmd_ready, rsp_valid, busy, and all mem_*_en.
- All FIFOs and in-flight tracking are cleared.
- mem_*_addr, mem_*_data and rsp_data are 0.
REQ-027 Reset asserted mid-operation SHALL discard queued commands and in-flight reads.
- A read returning after reset deassertion SHALL NOT produce a response.
REQ-028 cmd_ready SHALL go high in the first cycle after rst deasserts.

Verification
REQ-029 Two back-to-back writes to the same address: (0x05, 0x11111111) then (0x05, 0x22222222) -> both issued in one cycle with wr0_data=0x11111111 and wr1_data=0x22222222; a subsequent read of 0x05 returns 0x22222222.
REQ-030 Write (0x10, 0xA5A5A5A5) followed by a read of 0x10 -> the write and the read issue in different cycles, mem_rd0_en is never high alongside a write enable, and rsp_data is 0xA5A5A5A5.
REQ-031 Four reads with rsp_ready held low -> exactly 2 reads issued, rsp_valid high with the first datum stable, and issuance resumes one cycle after each pop.
REQ-032 Push CMD_DEPTH commands while the dispatcher is stalled -> cmd_ready goes low, and a 5th cmd_valid is not accepted until a pop occurs.
REQ-033 Assert rst with 1 read in flight and 3 commands queued -> all outputs reach their reset values asynchronously, no response appears after deassertion, and cmd_ready is 1 in the next cycle.
REQ-034 Random mix of 1000 reads and writes checked against a reference memory model -> all responses match and arrive in order, and pointer wrap-around is exercised at least 10 times.
